flag_unit: RTL and testbench
============================

Name: flag_unit

Overview:
- Producer end of the branch-condition interface: owns the architectural Z/V/N flag register and drives the 3-bit flag bus {Z,V,N} used by next-PC logic.
- Captures flags from the EX-stage ALU result using per-opcode update rules.
- Tracks in-flight flag writers so decode can hold a conditional branch until its flags are final.
- Sits between the EX stage (ALU) and the ID-stage next-PC logic.

Parameters:
- DW, 16, ALU result width.
- MAX_INFLIGHT, 2, saturation limit of the in-flight flag-writer counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  pipeline stall; freezes EX-side updates and counter transfers.
- flush  input  1  kills the instruction currently in EX (mispredict/redirect).
- id_advance  input  1  instruction moves ID->EX this cycle.
- id_sets_flags  input  1  the advancing ID instruction is a flag writer.
- ex_valid  input  1  EX holds a live instruction.
- ex_opcode  input  4  EX instruction opcode.
- alu_result  input  DW  EX ALU output.
- alu_ovfl  input  1  signed overflow from the EX adder.
- F  output  3  flag bus {Z,V,N}: bit2=Z, bit1=V, bit0=N.
- flags_ready  output  1  high when no flag writer is in flight.
- inflight_err  output  1  sticky: counter overflow/underflow detected.

Behaviour:
- Reset (rst=1 at the edge): F=3'b000, flags_ready=1, inflight_err=0, inflight count=0. Reset mid-operation discards pending writes.
- Flag computation: Z = (alu_result == 0); N = alu_result[DW-1]; V = alu_ovfl.
- Update classes:
  - ADD 0000, SUB 0001: write Z, V and N.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: write Z only; V and N hold.
  - All other opcodes: no write.
- Write condition, wr = ex_valid & !stall & !flush & class!=none. F updates on the edge after wr, giving 1-cycle latency from EX to F.
- flush has priority over a write in the same cycle; a killed instruction never modifies F.
- In-flight counter:
  - Increment on id_advance & id_sets_flags & !stall.
  - Decrement when the EX flag writer leaves EX: ex_valid & class!=none & !stall, whether it writes or is flushed.
  - Simultaneous increment and decrement: count holds.
  - An increment at MAX_INFLIGHT or a decrement at 0 leaves the count unchanged and sets inflight_err. inflight_err clears only on rst.
- flags_ready = (count == 0). This output is registered-state derived and has no combinational path from alu_result.
- stall: F, count and inflight_err all hold.

Optional Feature:
- FLAG_BYPASS_EN defined:
  - When wr=1, F presents the newly computed flags combinationally in the same cycle, merged per class (Z-only ops pass through the registered V and N).
  - flags_ready = (count==0) | (count==1 & wr & decrement-this-cycle).
  - Branch resolves with zero bubble.
- Undefined: F and flags_ready are purely registered, as described above.

Decomposition:
- Shared package flag_pkg:
  - opcode localparams (OP_ADD..OP_HLT);
  - flag bit indices FLAG_Z=2, FLAG_V=1, FLAG_N=0;
  - update-class encoding CLS_NONE / CLS_ZVN / CLS_Z.
- One sub-module, flag_class_decode: combinational ex_opcode -> 2-bit class.
- Counter and flag register stay in flag_unit.

Test Plan:
- Reset: hold rst 2 cycles with junk inputs -> F=000, flags_ready=1, inflight_err=0.
- ADD overflow: alu_result=16'h8000, alu_ovfl=1, opcode 0000, ex_valid=1 -> next cycle F=3'b011.
- Z-only update: F=011, then XOR with alu_result=0 -> F=3'b111 (V, N held); then LW with result 0x0000 -> F unchanged.
- Flush precedence: SUB with result 0 and flush=1 -> F unchanged; count decrements to 0.
- Counter: id_advance & id_sets_flags -> flags_ready=0 one cycle later; EX SUB completes -> flags_ready=1. Increment with count=2 -> inflight_err=1 and stays 1.
- Stall: stall=1 while ADD (result 0x0001) is in EX for 3 cycles -> F and count frozen; release -> F=000 next cycle.
- FLAG_BYPASS_EN build: SUB with result 0 -> F=100 in the same cycle and flags_ready=1 in that cycle.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared definitions for the flag unit: opcodes, flag bit positions, update classes.
package flag_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRA = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;
    localparam logic [3:0] OP_LW  = 4'h7;
    localparam logic [3:0] OP_SW  = 4'h8;
    localparam logic [3:0] OP_BR  = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_NOP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic [1:0] {
        CLS_NONE = 2'b00,
        CLS_ZVN  = 2'b01,
        CLS_Z    = 2'b10
    } flag_cls_e;

endpackage

// File: rtl/flag_class_decode.sv
// Maps an EX opcode to its flag update class (none, Z/V/N, or Z only).
module flag_class_decode
    import flag_pkg::*;
(
    input  logic [3:0] opcode,
    output flag_cls_e  cls
);

    always_comb begin
        cls = CLS_NONE;
        unique case (opcode)
            OP_ADD, OP_SUB:                 cls = CLS_ZVN;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: cls = CLS_Z;
            default:                        cls = CLS_NONE;
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// Architectural Z/V/N flag register plus in-flight flag-writer tracking.
// Define FLAG_BYPASS_EN to forward same-cycle EX flags onto F and flags_ready.
module flag_unit
    import flag_pkg::*;
#(
    parameter int unsigned DW           = 16,
    parameter int unsigned MAX_INFLIGHT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_advance,
    input  logic          id_sets_flags,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_ovfl,
    output logic [2:0]    F,
    output logic          flags_ready,
    output logic          inflight_err
);

    localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

    flag_cls_e     cls;
    logic [2:0]    f_q;
    logic [2:0]    f_new;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          err_q;
    logic          err_d;
    logic          wr;
    logic          inc;
    logic          dec;

    flag_class_decode u_class_decode (
        .opcode (ex_opcode),
        .cls    (cls)
    );

    assign wr  = ex_valid & ~stall & ~flush & (cls != CLS_NONE);
    assign inc = id_advance & id_sets_flags & ~stall;
    // A flushed writer still leaves EX, so it retires its in-flight slot.
    assign dec = ex_valid & ~stall & (cls != CLS_NONE);

    always_comb begin
        f_new         = f_q;
        f_new[FLAG_Z] = (alu_result == '0);
        if (cls == CLS_ZVN) begin
            f_new[FLAG_V] = alu_ovfl;
            f_new[FLAG_N] = alu_result[DW-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (inc && !dec) begin
            if (cnt_q == CW'(MAX_INFLIGHT)) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (dec && !inc) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q   <= 3'b000;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (wr) begin
                f_q <= f_new;
            end
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

`ifdef FLAG_BYPASS_EN
    assign F           = wr ? f_new : f_q;
    assign flags_ready = (cnt_q == '0) | ((cnt_q == CW'(1)) & wr & dec);
`else
    assign F           = f_q;
    assign flags_ready = (cnt_q == '0);
`endif

    assign inflight_err = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit (default build): directed plan then random traffic.
module tb_flag_unit;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          flush;
    logic          id_advance;
    logic          id_sets_flags;
    logic          ex_valid;
    logic [3:0]    ex_opcode;
    logic [DW-1:0] alu_result;
    logic          alu_ovfl;
    logic [2:0]    F;
    logic          flags_ready;
    logic          inflight_err;

    int total = 0;
    int bad   = 0;

    // Reference state
    bit m_z, m_v, m_n;
    int m_cnt;
    bit m_err;

    always #5 clk = ~clk;

    flag_unit #(
        .DW           (DW),
        .MAX_INFLIGHT (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .id_advance    (id_advance),
        .id_sets_flags (id_sets_flags),
        .ex_valid      (ex_valid),
        .ex_opcode     (ex_opcode),
        .alu_result    (alu_result),
        .alu_ovfl      (alu_ovfl),
        .F             (F),
        .flags_ready   (flags_ready),
        .inflight_err  (inflight_err)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0 = no flag write, 1 = Z/V/N, 2 = Z only
    function automatic int op_class(input logic [3:0] op);
        case (op)
            4'h0, 4'h1:             return 1;
            4'h2, 4'h4, 4'h5, 4'h6: return 2;
            default:                return 0;
        endcase
    endfunction

    task automatic idle();
        rst = 0; stall = 0; flush = 0; id_advance = 0; id_sets_flags = 0;
        ex_valid = 0; ex_opcode = 4'hE; alu_result = '0; alu_ovfl = 0;
    endtask

    task automatic step();
        int  cls;
        bit  inc, dec;
        @(posedge clk);
        if (rst) begin
            m_z = 0; m_v = 0; m_n = 0; m_cnt = 0; m_err = 0;
        end else if (!stall) begin
            cls = op_class(ex_opcode);
            if (ex_valid && !flush && cls != 0) begin
                m_z = (alu_result == 0);
                if (cls == 1) begin
                    m_v = alu_ovfl;
                    m_n = alu_result[DW-1];
                end
            end
            inc = id_advance && id_sets_flags;
            dec = ex_valid && cls != 0;
            if (inc && !dec) begin
                if (m_cnt == 2) m_err = 1; else m_cnt++;
            end else if (dec && !inc) begin
                if (m_cnt == 0) m_err = 1; else m_cnt--;
            end
        end
        #1;
        check("F", 8'(F), 8'({m_z, m_v, m_n}));
        check("flags_ready", 8'(flags_ready), 8'(m_cnt == 0));
        check("inflight_err", 8'(inflight_err), 8'(m_err));
    endtask

    task automatic ex_op(input logic [3:0] op, input logic [15:0] res, input logic ov);
        ex_valid = 1; ex_opcode = op; alu_result = res; alu_ovfl = ov;
    endtask

    initial begin
        idle();
        // Reset with junk inputs
        rst = 1; stall = 1; flush = 1; id_advance = 1; id_sets_flags = 1;
        ex_valid = 1; ex_opcode = 4'h0; alu_result = 16'h0000; alu_ovfl = 1;
        step(); step();
        check("rst_F", 8'(F), 8'h00);
        check("rst_ready", 8'(flags_ready), 8'h01);
        check("rst_err", 8'(inflight_err), 8'h00);

        // Writer enters the pipe
        idle(); id_advance = 1; id_sets_flags = 1;
        step();
        check("cnt1_ready", 8'(flags_ready), 8'h00);

        // ADD overflow, next writer follows (count holds)
        ex_op(4'h0, 16'h8000, 1'b1);
        step();
        check("add_ovfl_F", 8'(F), 8'h03);

        // XOR zero: Z set, V/N held
        ex_op(4'h2, 16'h0000, 1'b0);
        step();
        check("xor_z_F", 8'(F), 8'h07);

        // LW: no flag write, no counter effect
        idle(); ex_op(4'h7, 16'h0000, 1'b1);
        step();
        check("lw_F", 8'(F), 8'h07);

        // Flushed SUB: F unchanged, slot retired
        ex_op(4'h1, 16'h0000, 1'b0); flush = 1;
        step();
        check("flush_F", 8'(F), 8'h07);
        check("flush_ready", 8'(flags_ready), 8'h01);

        // Counter round trip
        idle(); id_advance = 1; id_sets_flags = 1;
        step();
        check("inc_ready", 8'(flags_ready), 8'h00);
        idle(); ex_op(4'h1, 16'h8000, 1'b0);
        step();
        check("sub_ready", 8'(flags_ready), 8'h01);
        check("sub_F", 8'(F), 8'h01);

        // Stall freezes everything
        idle(); id_advance = 1; id_sets_flags = 1;
        step();
        ex_op(4'h0, 16'h0001, 1'b0); stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_F", 8'(F), 8'h01);
            check("stall_ready", 8'(flags_ready), 8'h00);
        end
        stall = 0; id_advance = 0;
        step();
        check("release_F", 8'(F), 8'h00);
        check("release_ready", 8'(flags_ready), 8'h01);

        // Saturation -> sticky error
        idle(); id_advance = 1; id_sets_flags = 1;
        step(); step(); step();
        check("sat_err", 8'(inflight_err), 8'h01);
        idle();
        step(); step();
        check("sticky_err", 8'(inflight_err), 8'h01);
        rst = 1;
        step();
        check("err_clear", 8'(inflight_err), 8'h00);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(63) == 0);
            stall         = ($urandom_range(3) == 0);
            flush         = ($urandom_range(5) == 0);
            id_advance    = $urandom_range(1) == 1;
            id_sets_flags = $urandom_range(1) == 1;
            ex_valid      = $urandom_range(1) == 1;
            ex_opcode     = 4'($urandom_range(15));
            alu_result    = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom());
            alu_ovfl      = $urandom_range(1) == 1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
